// File: rtl/exec_mem_responder_if.sv
// EXEC data-memory bus between instr_exec (master) and the memory responder
// (slave).
//   exec_rd_req/exec_rd_addr               read request, sampled each posedge
//   exec_wr_req/exec_wr_addr/exec_wr_data  write request, sampled each posedge
//   exec_rd_data/rd_valid                  read result returned by the responder
interface exec_mem_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  rd_valid;

  modport master (
    output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    input  exec_rd_data, rd_valid
  );

  modport slave (
    input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    output exec_rd_data, rd_valid
  );
endinterface

// File: rtl/exec_mem_responder.sv
// Memory-side responder for the EXEC data-memory interface. It backs a
// 2**ADDR_WIDTH x DATA_WIDTH word store, returns read data after RD_LATENCY
// cycles through a pipeline, counts the requests it accepts and flags protocol
// misuse.
//   clk, reset_n          clock (posedge) and asynchronous active-low reset
//   bus (slave)           exec read/write requests and the read result
//   ld_en/ld_addr/ld_data bench preload port; it does not touch the counters
//   rd_count/wr_count     saturating counts of accepted requests
//   proto_err             sticky protocol-violation flag
module exec_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  exec_mem_responder_if.slave   bus,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  proto_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_bad_latency
    $fatal(1, "exec_mem_responder: RD_LATENCY=%0d outside 1..4", RD_LATENCY);
  end

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [RD_LATENCY-1:0] vld_r;
  logic [DATA_WIDTH-1:0] dat_r [RD_LATENCY];
  logic [CNT_WIDTH-1:0]  rd_count_r;
  logic [CNT_WIDTH-1:0]  wr_count_r;
  logic                  proto_err_r;

  logic                  rd_addr_bad_s;
  logic                  wr_addr_bad_s;
  logic                  rd_fire_s;
  logic                  wr_fire_s;
  logic                  misuse_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // An address with X/Z bits only exists in simulation; hardware never sees it.
  function automatic logic addr_unknown(input logic [ADDR_WIDTH-1:0] addr);
`ifndef SYNTHESIS
    addr_unknown = $isunknown(addr);
`else
    addr_unknown = 1'b0;
`endif
  endfunction

  // Request qualification: an unknown-address request is dropped but still flagged.
  always_comb begin
    rd_addr_bad_s = bus.exec_rd_req && addr_unknown(bus.exec_rd_addr);
    wr_addr_bad_s = bus.exec_wr_req && addr_unknown(bus.exec_wr_addr);
    rd_fire_s     = bus.exec_rd_req && !rd_addr_bad_s;
    wr_fire_s     = bus.exec_wr_req && !wr_addr_bad_s;
    misuse_s      = (bus.exec_rd_req && bus.exec_wr_req) ||
                    (ld_en && (bus.exec_rd_req || bus.exec_wr_req)) ||
                    rd_addr_bad_s || wr_addr_bad_s;
    rd_word_s     = mem_r[bus.exec_rd_addr];
  end

  // Word store, deliberately not reset. The preload write is issued after the
  // exec write, so it wins a same-address collision. The read above uses the
  // pre-edge contents, which gives read-before-write.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[bus.exec_wr_addr] <= bus.exec_wr_data;
    end
    if (ld_en) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

  // Read pipeline. Each stage updates its data only when a result moves into
  // it, so the last stage holds the last returned word while rd_valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_r <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= rd_fire_s;
      if (rd_fire_s) begin
        dat_r[0] <= rd_word_s;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  // Saturating request counters and the sticky misuse flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_r  <= '0;
      wr_count_r  <= '0;
      proto_err_r <= 1'b0;
    end else begin
      if (rd_fire_s && (rd_count_r != {CNT_WIDTH{1'b1}})) begin
        rd_count_r <= rd_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (wr_fire_s && (wr_count_r != {CNT_WIDTH{1'b1}})) begin
        wr_count_r <= wr_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (misuse_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign bus.exec_rd_data = dat_r[RD_LATENCY-1];
  assign bus.rd_valid     = vld_r[RD_LATENCY-1];
  assign rd_count         = rd_count_r;
  assign wr_count         = wr_count_r;
  assign proto_err        = proto_err_r;

endmodule

// File: tb/tb_exec_mem_responder.sv
// Bench for exec_mem_responder. Two instances receive identical stimulus:
// instance a has RD_LATENCY=1 and CNT_WIDTH=4, and instance b has RD_LATENCY=3
// and CNT_WIDTH=16. A reference model predicts each output on every cycle.
module tb_exec_mem_responder;
  logic        clk;
  logic        reset_n;
  logic        rd_req, wr_req, ld_en;
  logic [11:0] rd_addr, wr_addr, wr_data, ld_addr, ld_data;
  logic [3:0]  rdc_a, wrc_a;
  logic [15:0] rdc_b, wrc_b;
  logic        perr_a, perr_b;

  exec_mem_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) ifa ();
  exec_mem_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) ifb ();

  assign ifa.exec_rd_req  = rd_req;
  assign ifa.exec_rd_addr = rd_addr;
  assign ifa.exec_wr_req  = wr_req;
  assign ifa.exec_wr_addr = wr_addr;
  assign ifa.exec_wr_data = wr_data;
  assign ifb.exec_rd_req  = rd_req;
  assign ifb.exec_rd_addr = rd_addr;
  assign ifb.exec_wr_req  = wr_req;
  assign ifb.exec_wr_addr = wr_addr;
  assign ifb.exec_wr_data = wr_data;

  exec_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LATENCY(1), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .rd_count(rdc_a), .wr_count(wrc_a), .proto_err(perr_a));

  exec_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LATENCY(3), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .rd_count(rdc_b), .wr_count(wrc_b), .proto_err(perr_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model. Index 0 models instance a and index 1 models instance b.
  // Each read is logged by edge number, and its result is due RD_LATENCY-1
  // edges later.
  logic [11:0] mem_m [0:4095];
  int          k;
  bit          hv [2][8];
  logic [11:0] hd [2][8];
  bit          ev [2];
  logic [11:0] el [2];
  int          rc [2];
  int          wc [2];
  bit          pe;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(input int d);
    return (d == 0) ? 15 : 65535;
  endfunction

  task automatic model_reset();
    k = 0;
    pe = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ev[d] = 1'b0; el[d] = 12'd0; rc[d] = 0; wc[d] = 0;
      for (int j = 0; j < 8; j++) begin
        hv[d][j] = 1'b0; hd[d][j] = 12'd0;
      end
    end
  endtask

  task automatic model_edge();
    logic [11:0] rw;
    int j;
    rw = mem_m[rd_addr];
    for (int d = 0; d < 2; d++) begin
      hv[d][k % 8] = rd_req;
      hd[d][k % 8] = rw;
      if (rd_req && rc[d] < cmax(d)) rc[d]++;
      if (wr_req && wc[d] < cmax(d)) wc[d]++;
    end
    if ((rd_req && wr_req) || (ld_en && (rd_req || wr_req))) pe = 1'b1;
    if (wr_req) mem_m[wr_addr] = wr_data;
    if (ld_en) mem_m[ld_addr] = ld_data;
    for (int d = 0; d < 2; d++) begin
      j = k - lat(d) + 1;
      ev[d] = (j >= 0) && hv[d][j % 8];
      if (ev[d]) el[d] = hd[d][j % 8];
    end
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_valid", {31'd0, ifa.rd_valid}, {31'd0, ev[0]});
    chk("a_data", {20'd0, ifa.exec_rd_data}, {20'd0, el[0]});
    chk("a_rd_count", {28'd0, rdc_a}, rc[0]);
    chk("a_wr_count", {28'd0, wrc_a}, wc[0]);
    chk("a_proto_err", {31'd0, perr_a}, {31'd0, pe});
    chk("b_valid", {31'd0, ifb.rd_valid}, {31'd0, ev[1]});
    chk("b_data", {20'd0, ifb.exec_rd_data}, {20'd0, el[1]});
    chk("b_rd_count", {16'd0, rdc_b}, rc[1]);
    chk("b_wr_count", {16'd0, wrc_b}, wc[1]);
    chk("b_proto_err", {31'd0, perr_b}, {31'd0, pe});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    rd_req = 1'b0; wr_req = 1'b0; ld_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    idle(); rd_req = 1'b1; rd_addr = a;
  endtask

  task automatic ld(input logic [11:0] a, input logic [11:0] v);
    idle(); ld_en = 1'b1; ld_addr = a; ld_data = v;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    rd_addr = 12'd0; wr_addr = 12'd0; wr_data = 12'd0; ld_addr = 12'd0; ld_data = 12'd0;
    model_reset();
    tick(); tick();
    reset_n = 1'b1;

    // Preload the addresses used below.
    for (int a = 0; a < 16; a++) begin
      ld(a[11:0], 12'($urandom)); tick();
    end
    ld(12'd1, 12'o11);    tick();
    ld(12'd2, 12'o22);    tick();
    ld(12'd3, 12'o33);    tick();
    ld(12'o10, 12'o0001); tick();
    ld(12'o200, 12'o1234); tick();
    idle(); tick(); tick(); tick();

    // Preloaded word, read back one cycle after the request.
    rd(12'o200); tick();
    chk("t1_valid", {31'd0, ifa.rd_valid}, 32'd1);
    chk("t1_data", {20'd0, ifa.exec_rd_data}, 32'o1234);
    chk("t1_rd_count", {28'd0, rdc_a}, 32'd1);
    idle(); tick();
    chk("t1_valid_drop", {31'd0, ifa.rd_valid}, 32'd0);
    chk("t1_data_hold", {20'd0, ifa.exec_rd_data}, 32'o1234);

    // Write, then read the same address on the next cycle.
    idle(); wr_req = 1'b1; wr_addr = 12'o50; wr_data = 12'o7777; tick();
    rd(12'o50); tick();
    chk("t2_data", {20'd0, ifa.exec_rd_data}, 32'o7777);
    chk("t2_wr_count", {28'd0, wrc_a}, 32'd1);
    chk("t2_perr", {31'd0, perr_a}, 32'd0);

    // Read and write on the same edge: the read returns the old word.
    rd(12'o10); wr_req = 1'b1; wr_addr = 12'o10; wr_data = 12'o0002; tick();
    chk("t3_old", {20'd0, ifa.exec_rd_data}, 32'o0001);
    chk("t3_perr", {31'd0, perr_a}, 32'd1);
    rd(12'o10); tick();
    chk("t3_new", {20'd0, ifa.exec_rd_data}, 32'o0002);
    idle(); tick(); tick(); tick();
    chk("t3_perr_sticky", {31'd0, perr_b}, 32'd1);

    // RD_LATENCY=3, back-to-back reads of addresses 1, 2 and 3.
    rd(12'd1); tick();
    chk("t4_v0", {31'd0, ifb.rd_valid}, 32'd0);
    rd(12'd2); tick();
    chk("t4_v1", {31'd0, ifb.rd_valid}, 32'd0);
    rd(12'd3); tick();
    chk("t4_d1", {20'd0, ifb.exec_rd_data}, 32'o11);
    chk("t4_vd1", {31'd0, ifb.rd_valid}, 32'd1);
    idle(); tick();
    chk("t4_d2", {20'd0, ifb.exec_rd_data}, 32'o22);
    tick();
    chk("t4_d3", {20'd0, ifb.exec_rd_data}, 32'o33);
    chk("t4_vd3", {31'd0, ifb.rd_valid}, 32'd1);
    tick();
    chk("t4_vend", {31'd0, ifb.rd_valid}, 32'd0);

    // Read counter saturation on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      rd(12'd5); tick();
    end
    chk("sat_rd", {28'd0, rdc_a}, 32'hF);
    tick();
    chk("sat_hold", {28'd0, rdc_a}, 32'hF);
    idle(); tick(); tick(); tick();

    // Reset asserted with two reads in flight on instance b.
    rd(12'd2); tick();
    rd(12'd3); tick();
    idle();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_b_valid", {31'd0, ifb.rd_valid}, 32'd0);
    chk("rst_b_data", {20'd0, ifb.exec_rd_data}, 32'd0);
    chk("rst_a_rd_count", {28'd0, rdc_a}, 32'd0);
    chk("rst_perr", {31'd0, perr_b}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_valid", {31'd0, ifb.rd_valid}, 32'd0);
    end
    rd(12'd3); tick();
    idle(); tick(); tick();
    chk("rst_mem_kept", {20'd0, ifb.exec_rd_data}, 32'o33);
    chk("rst_mem_valid", {31'd0, ifb.rd_valid}, 32'd1);

    // Random traffic checked against the model on every cycle.
    for (int i = 0; i < 400; i++) begin
      idle();
      rd_req  = ($urandom % 2) == 0;
      wr_req  = ($urandom % 4) == 0;
      ld_en   = ($urandom % 8) == 0;
      rd_addr = 12'($urandom % 16);
      wr_addr = 12'($urandom % 16);
      ld_addr = 12'($urandom % 16);
      wr_data = 12'($urandom);
      ld_data = 12'($urandom);
      tick();
    end
    idle(); tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
